// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
//   Bundles the scanned 7-segment display pins and the decoded result bus
//   for seg7_scan_decoder.
//   master : drives seg_n / dig_sel_n / err_clr, observes the decoded outputs
//   slave  : the decoder side (consumes pins, produces decoded outputs)
//   seg_n       [6:0]            segment lines, active-low, bit0=a .. bit6=g
//   dig_sel_n   [NUM_DIGITS-1:0] digit enables, active-low, one-hot-low
//   err_clr                      synchronous clear of err_flag
//   digits      [4*NUM_DIGITS-1:0] decoded nibble per position
//   digit_valid [NUM_DIGITS-1:0] position holds a decoded hex value
//   update                       one-cycle pulse per commit
//   upd_idx     [2:0]            committed position (valid while update=1)
//   err_flag                     sticky illegal-pattern indicator
interface seg7_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   dig_sel_n;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    update;
    logic [2:0]              upd_idx;
    logic                    err_flag;

    modport master (
        output seg_n, dig_sel_n, err_clr,
        input  digits, digit_valid, update, upd_idx, err_flag
    );

    modport slave (
        input  seg_n, dig_sel_n, err_clr,
        output digits, digit_valid, update, upd_idx, err_flag
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Samples a multiplexed (scanned) 7-segment display, waits for each
//   {dig_sel_n, seg_n} pattern to be stable for STABLE_CYCLES samples, then
//   decodes it into a per-position hex nibble.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : seg7_scan_decoder_if.slave (pins in, decoded results out)
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_decoder_if.slave   bus
);

    localparam int unsigned PW        = NUM_DIGITS + 7;
    localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_HELD
    } state_t;

    // Two-flop synchronizer plus one history stage for change detection.
    // All-ones is the idle/blank pattern, so reset never looks like a change.
    logic [PW-1:0] sync1, sync2, prev;
    logic          changed;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          commit;

    logic [NUM_DIGITS-1:0]   sel_low;
    logic                    onehot, multi;
    logic [2:0]              sel_idx;
    logic [5:0]              dec;
    logic                    legal, blank;
    logic [3:0]              nib;
    logic                    set_err;

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    update_q;
    logic [2:0]              idx_q;
    logic                    err_q;

    // Returns {legal, blank, nibble} for an active-low segment pattern.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        r = '0;
        case (s)
            7'h40: r = {2'b10, 4'h0};
            7'h79: r = {2'b10, 4'h1};
            7'h24: r = {2'b10, 4'h2};
            7'h30: r = {2'b10, 4'h3};
            7'h19: r = {2'b10, 4'h4};
            7'h12: r = {2'b10, 4'h5};
            7'h02: r = {2'b10, 4'h6};
            7'h78: r = {2'b10, 4'h7};
            7'h00: r = {2'b10, 4'h8};
            7'h10: r = {2'b10, 4'h9};
            7'h08: r = {2'b10, 4'hA};
            7'h03: r = {2'b10, 4'hB};
            7'h46: r = {2'b10, 4'hC};
            7'h21: r = {2'b10, 4'hD};
            7'h06: r = {2'b10, 4'hE};
            7'h0E: r = {2'b10, 4'hF};
            7'h7F: r = {2'b01, 4'h0};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {bus.dig_sel_n, bus.seg_n};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign changed = (sync2 != prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Commit is taken on the cycle the counter sits at the limit; the
    // pattern being committed is 'prev', which is still the stable value
    // even if sync2 has just moved on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (changed) begin
                    state_d = S_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == STABLE_LIM) begin
                    commit = 1'b1;
                    if (changed) begin
                        cnt_d = 8'd1;
                    end else begin
                        state_d = S_HELD;
                    end
                end else if (changed) begin
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HELD: begin
                if (changed) begin
                    state_d = S_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign sel_low = ~prev[PW-1:7];
    assign onehot  = ($countones(sel_low) == 1);
    assign multi   = ($countones(sel_low) > 1);
    assign dec     = decode(prev[6:0]);
    assign legal   = dec[5];
    assign blank   = dec[4];
    assign nib     = dec[3:0];
    assign set_err = commit && (multi || (onehot && !legal && !blank));

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_low[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (commit && onehot) begin
                update_q <= 1'b1;
                idx_q    <= sel_idx;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_low[i]) begin
                        if (legal) begin
                            digits_q[4*i +: 4] <= nib;
                            valid_q[i]         <= 1'b1;
                        end else begin
                            // blank or illegal: position no longer holds a value
                            valid_q[i] <= 1'b0;
                        end
                    end
                end
            end
            // A new error takes priority over a simultaneous clear.
            if (set_err) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.update      = update_q;
    assign bus.upd_idx     = idx_q;
    assign bus.err_flag    = err_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of scanned digit positions (1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 8, consecutive identical samples required before commit (2..255).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port seg_n  in  7  segment lines, active-low, bit0=a .. bit6=g, asynchronous to clk.
REQ-006 SHALL have port dig_sel_n  in  NUM_DIGITS  digit enables, active-low, expected one-hot-low, asynchronous to clk.
REQ-007 SHALL have port err_clr  in  1  synchronous clear of err_flag.
REQ-008 SHALL have port digits  out  4*NUM_DIGITS  decoded nibble per position; position i at bits [4i+3:4i].
REQ-009 SHALL have port digit_valid  out  NUM_DIGITS  position holds a decoded hex value.
REQ-010 SHALL have port update  out  1  one-cycle pulse on each commit.
REQ-011 SHALL have port upd_idx  out  3  position index of the current commit, meaningful only while update=1.
REQ-012 SHALL have port err_flag  out  1  sticky illegal-pattern indicator.

Function
REQ-013 SHALL pass seg_n and dig_sel_n through a two-flop synchronizer before any other use.
REQ-014 SHALL decode the synchronized pattern (hex) as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F, 7F->blank; every other pattern is illegal.
REQ-015 SHALL run FSM WAIT/SETTLE/HELD: WAIT is entered from reset; any change in the synchronized {dig_sel_n, seg_n} pair moves to SETTLE with the stability counter at 1.
REQ-016 SHALL, in SETTLE, increment the counter on each unchanged sample and return to SETTLE with counter=1 on any change.
REQ-017 SHALL commit when the counter reaches STABLE_CYCLES, then enter HELD; HELD stays until the pair changes, which goes to SETTLE; exactly one commit per stable interval.
REQ-018 SHALL, on commit with exactly one dig_sel_n bit low at index i and a legal hex pattern, write digits[i], set digit_valid[i], pulse update with upd_idx=i.
REQ-019 SHALL, on commit with one-hot-low selection and the blank pattern, clear digit_valid[i], leave digits[i] unchanged, and pulse update.
REQ-020 SHALL, on commit with one-hot-low selection and an illegal pattern, clear digit_valid[i], set err_flag, and pulse update.
REQ-021 SHALL, on commit with all dig_sel_n high, do nothing: no update and no flag.
REQ-022 SHALL, on commit with more than one dig_sel_n bit low, set err_flag only: no update and no position change.
REQ-023 SHALL assert update in the cycle STABLE_CYCLES+2 clocks after the first edge at which the pin values are stable; outputs are registered.
REQ-024 SHALL, when err_clr is high in the same cycle as a new error, leave err_flag set; the set wins.
REQ-025 SHALL keep positions other than the committed index unchanged on every commit.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force digits=0, digit_valid=0, update=0, upd_idx=0, err_flag=0, FSM=WAIT, counter=0, and synchronizer flops to all-ones (idle/blank).
REQ-027 SHALL, on reset mid-SETTLE, discard the pending sample; after release, no commit occurs until the pair differs from all-ones and then stays stable.

Verification
REQ-028 SHALL test: dig_sel_n=1110, seg_n=0x24 held 20 cycles -> a single update pulse at cycle 10 after it is stable, upd_idx=0, digits[3:0]=2, digit_valid=0001.
REQ-029 SHALL test: round-robin scan over 4 positions with 0x30/0x08/0x46/0x0E, each held 12 cycles -> digits=0xFCA3 (pos3..pos0), digit_valid=1111, 4 update pulses per scan round.
REQ-030 SHALL test: position 1 with seg_n toggling between 0x40 and 0x79 every 5 cycles (STABLE_CYCLES=8) -> no update; digit_valid[1] unchanged.
REQ-031 SHALL test: position 2 with seg_n=0x7E -> update, err_flag=1, digit_valid[2]=0; dig_sel_n=1001 stable -> err_flag=1, no update; err_clr together with a new error -> err_flag stays 1.
REQ-032 SHALL test: valid position 3 holding 0x5, then blank 0x7F -> digit_valid[3]=0 and digits[15:12]=5 retained.
REQ-033 SHALL test: rst_n pulsed low during SETTLE -> all outputs 0 immediately (asynchronously), and no spurious update after release.
